// File: rtl/ctrl_uart_rx.sv
// ctrl_uart_rx: 8N1 UART receiver feeding a small byte FIFO.
// The serial line is synchronised, edge-detected and sampled mid-bit by a
// five-state FSM. Good bytes are pushed into the FIFO one cycle after the
// stop-bit sample. Framing and overflow errors are reported as one-cycle
// pulses.
// Stream handshake: a byte transfers on a rising clock edge where
// o_rx_valid && i_rx_ready. While o_rx_valid is high and i_rx_ready is low,
// o_rx_data holds steady, and o_rx_valid only drops after a pop.
module ctrl_uart_rx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_err_frame,
  output logic       o_err_overflow,
  output logic       o_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLK_DIV / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Input conditioning
  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic w_fall;

  // Receiver FSM
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_err_frame;
  logic          w_expire;

  // FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_ovf;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_fall   = r_hist & ~r_sync2;
  // START waits half a bit so the later samples land mid-bit
  assign w_expire = (r_state == S_START) ? (r_cnt == HALF_LAST)
                                         : (r_cnt == FULL_LAST);

  // Frame FSM: baud counting, bit sampling, push and framing-error pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
      r_err_frame <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_err_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_expire) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_expire) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_sync2;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_expire) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
              r_state     <= S_IDLE;
            end else begin
              r_err_frame <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line reports one framing error, then waits for idle
          r_cnt <= '0;
          if (r_sync2) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = ~w_empty & i_rx_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts
  assign w_push  = r_push & (~w_full | w_pop);

  // Byte FIFO storage, pointers and overflow pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= r_push_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_ovf <= r_push & w_full & ~w_pop;
    end
  end

  assign o_rx_data      = r_mem[r_rd[AW-1:0]];
  assign o_rx_valid     = ~w_empty;
  assign o_err_frame    = r_err_frame;
  assign o_err_overflow = r_ovf;
  assign o_busy         = (r_state != S_IDLE);

endmodule
